// File: rtl/regfile_sb_if.sv
// Register-file scoreboard bus: two read ports, two write ports, reserve and bulk clear.
// Latency: carries combinational reads and single-edge writes; no timing of its own.
// Backpressure: none on the bus; writes and reservations are dropped while clr_busy is high.
interface regfile_sb_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_rdy_a;
    logic              rd_rdy_b;

    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;

    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;

    logic              clr_req;
    logic              clr_busy;

    // Issue/writeback side driving the register file.
    modport master (
        output rd_addr_a, rd_addr_b,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output rsv_en, rsv_addr, clr_req,
        input  rd_data_a, rd_data_b, rd_rdy_a, rd_rdy_b, clr_busy
    );

    // The register file itself.
    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  rsv_en, rsv_addr, clr_req,
        output rd_data_a, rd_data_b, rd_rdy_a, rd_rdy_b, clr_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// 2R/2W register file with per-register pending (scoreboard) bits and a bulk-clear sweep.
// Latency: reads combinational, writes/reserves visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: clr_busy high for NREGS-1 cycles; writes and reserves during it are dropped.
module regfile_sb #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int ADDR_W = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              sweep;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d;

    logic wr0_acc, wr1_acc, rsv_acc, wr_same;

    // Register 0 is hard-wired, and the port is frozen during a sweep.
    assign wr0_acc = bus.wr0_en && !sweep && (bus.wr0_addr != '0);
    assign wr1_acc = bus.wr1_en && !sweep && (bus.wr1_addr != '0);
    assign rsv_acc = bus.rsv_en && !sweep && (bus.rsv_addr != '0);
    assign wr_same = wr0_acc && wr1_acc && (bus.wr0_addr == bus.wr1_addr);

    // Clear FSM state and sweep index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Clear FSM next state: start on clr_req, walk 1..NREGS-1 once, then stop.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sweep   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    idx_d   = FIRST_IDX;
                end
            end
            CLEAR: begin
                sweep = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = FIRST_IDX;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = FIRST_IDX;
            end
        endcase
    end

    assign bus.clr_busy = sweep;

    // Storage update: sweep zeroes one entry per cycle, otherwise the two write ports (wr1 wins).
    always_ff @(posedge clk) begin
        if (sweep) begin
            regs[idx_q] <= '0;
        end else begin
            if (wr0_acc && !wr_same) begin
                regs[bus.wr0_addr] <= bus.wr0_data;
            end
            if (wr1_acc) begin
                regs[bus.wr1_addr] <= bus.wr1_data;
            end
        end
    end

    // Pending next state: reserve beats a same-cycle write so the newer producer is tracked.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NREGS; i++) begin
            if (sweep && (idx_q == ADDR_W'(i))) begin
                pend_d[i] = 1'b0;
            end else if (rsv_acc && (bus.rsv_addr == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
            end else if ((wr0_acc && (bus.wr0_addr == ADDR_W'(i))) ||
                         (wr1_acc && (bus.wr1_addr == ADDR_W'(i)))) begin
                pend_d[i] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
    end

    // Pending bits are the only reset storage besides the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Read port A: zero register, optional same-cycle forwarding, then stored state.
    always_comb begin
        bus.rd_data_a = regs[bus.rd_addr_a];
        bus.rd_rdy_a  = !pend_q[bus.rd_addr_a];
`ifdef REGFILE_BYPASS_EN
        if (wr1_acc && (bus.wr1_addr == bus.rd_addr_a)) begin
            bus.rd_data_a = bus.wr1_data;
            bus.rd_rdy_a  = !(rsv_acc && (bus.rsv_addr == bus.rd_addr_a));
        end else if (wr0_acc && (bus.wr0_addr == bus.rd_addr_a)) begin
            bus.rd_data_a = bus.wr0_data;
            bus.rd_rdy_a  = !(rsv_acc && (bus.rsv_addr == bus.rd_addr_a));
        end
`endif
        if (bus.rd_addr_a == '0) begin
            bus.rd_data_a = '0;
            bus.rd_rdy_a  = 1'b1;
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        bus.rd_data_b = regs[bus.rd_addr_b];
        bus.rd_rdy_b  = !pend_q[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr1_acc && (bus.wr1_addr == bus.rd_addr_b)) begin
            bus.rd_data_b = bus.wr1_data;
            bus.rd_rdy_b  = !(rsv_acc && (bus.rsv_addr == bus.rd_addr_b));
        end else if (wr0_acc && (bus.wr0_addr == bus.rd_addr_b)) begin
            bus.rd_data_b = bus.wr0_data;
            bus.rd_rdy_b  = !(rsv_acc && (bus.rsv_addr == bus.rd_addr_b));
        end
`endif
        if (bus.rd_addr_b == '0) begin
            bus.rd_data_b = '0;
            bus.rd_rdy_b  = 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed scenarios plus randomized traffic against an array model.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled on the falling edge.
// Backpressure: model drops writes/reserves while its own clear sweep is active.
module tb_regfile_sb;
    localparam int DATA_W = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays, updated once per rising edge.
    logic [DATA_W-1:0] m_mem   [NREGS];
    bit                m_known [NREGS];
    bit                m_pend  [NREGS];
    bit                m_busy;
    int                m_idx;

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
        m_busy = 0;
        m_idx  = 1;
    endfunction

    function automatic void model_tick();
        if (m_busy) begin
            m_mem[m_idx]   = '0;
            m_known[m_idx] = 1;
            m_pend[m_idx]  = 0;
            m_idx++;
            if (m_idx == NREGS) m_busy = 0;
        end else begin
            if (bus.clr_req) begin
                m_busy = 1;
                m_idx  = 1;
            end
            if (bus.wr0_en && bus.wr0_addr != 0) begin
                m_mem[bus.wr0_addr]   = bus.wr0_data;
                m_known[bus.wr0_addr] = 1;
                m_pend[bus.wr0_addr]  = 0;
            end
            if (bus.wr1_en && bus.wr1_addr != 0) begin
                m_mem[bus.wr1_addr]   = bus.wr1_data;
                m_known[bus.wr1_addr] = 1;
                m_pend[bus.wr1_addr]  = 0;
            end
            if (bus.rsv_en && bus.rsv_addr != 0) m_pend[bus.rsv_addr] = 1;
        end
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!m_busy && bus.wr1_en && int'(bus.wr1_addr) == a) return bus.wr1_data;
        if (!m_busy && bus.wr0_en && int'(bus.wr0_addr) == a) return bus.wr0_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_rdy(input int a);
        if (a == 0) return 1'b1;
`ifdef REGFILE_BYPASS_EN
        if (!m_busy && ((bus.wr1_en && int'(bus.wr1_addr) == a) ||
                        (bus.wr0_en && int'(bus.wr0_addr) == a)))
            return !(bus.rsv_en && int'(bus.rsv_addr) == a);
`endif
        return !m_pend[a];
    endfunction

    function automatic bit exp_known(input int a);
        return (a == 0) || m_known[a];
    endfunction

    task automatic idle_inputs();
        bus.wr0_en  = 0; bus.wr1_en = 0; bus.rsv_en = 0; bus.clr_req = 0;
        bus.wr0_addr = '0; bus.wr1_addr = '0; bus.rsv_addr = '0;
        bus.wr0_data = '0; bus.wr1_data = '0;
    endtask

    // Advance one clock: model follows the edge, then inputs return to idle.
    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        for (int i = 0; i < NREGS; i++) m_known[i] = 0;
        model_reset();
        #3;
        checks++;
        if (bus.clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", bus.clr_busy);
        end
        for (int a = 0; a < NREGS; a++) begin
            bus.rd_addr_a = ADDR_W'(a);
            bus.rd_addr_b = ADDR_W'(NREGS - 1 - a);
            #1;
            checks++;
            if (bus.rd_rdy_a !== 1'b1 || bus.rd_rdy_b !== 1'b1) begin
                errors++;
                $display("FAIL reset_rdy[%0d]: got a=%b b=%b want 1/1", a, bus.rd_rdy_a, bus.rd_rdy_b);
            end
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        int  n = 0;
        bit  done = 0;
        bus.clr_req = 1;
        tick();
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.clr_busy === 1'b1) n++;
            else done = 1;
            if (!done) tick();
        end
        checks++;
        if (!done || n != NREGS - 1) begin
            errors++;
            $display("FAIL clear_len: got %0d busy cycles (ended=%0d) want %0d", n, done, NREGS - 1);
        end
        for (int a = 0; a < NREGS; a++) begin
            bus.rd_addr_a = ADDR_W'(a);
            bus.rd_addr_b = ADDR_W'(a);
            #1;
            checks++;
            if (bus.rd_data_a !== '0 || bus.rd_data_b !== '0 || bus.rd_rdy_a !== 1'b1 || bus.rd_rdy_b !== 1'b1) begin
                errors++;
                $display("FAIL clear_val[%0d]: got %h/%h rdy %b/%b want 0/0 rdy 1/1",
                         a, bus.rd_data_a, bus.rd_data_b, bus.rd_rdy_a, bus.rd_rdy_b);
            end
        end
        tick();
    endtask

    task automatic test_same_addr();
        bus.wr0_en = 1; bus.wr0_addr = 5; bus.wr0_data = 64'hAAAA;
        bus.wr1_en = 1; bus.wr1_addr = 5; bus.wr1_data = 64'h5555;
        tick();
        bus.rd_addr_a = 5;
        #1;
        checks++;
        if (bus.rd_data_a !== 64'h5555 || bus.rd_data_a !== exp_data(5)) begin
            errors++;
            $display("FAIL same_addr: got %h want 5555", bus.rd_data_a);
        end
    endtask

    task automatic test_pending();
        bus.rd_addr_a = 7;
        bus.rsv_en = 1; bus.rsv_addr = 7;
        tick();
        #1;
        checks++;
        if (bus.rd_rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL rsv_sets: got rdy %b want 0", bus.rd_rdy_a);
        end
        bus.wr0_en = 1; bus.wr0_addr = 7; bus.wr0_data = 64'h1234;
        tick();
        #1;
        checks++;
        if (bus.rd_rdy_a !== 1'b1 || bus.rd_data_a !== 64'h1234) begin
            errors++;
            $display("FAIL wr_clears: got rdy %b data %h want 1 1234", bus.rd_rdy_a, bus.rd_data_a);
        end
        bus.rsv_en = 1; bus.rsv_addr = 7;
        bus.wr0_en = 1; bus.wr0_addr = 7; bus.wr0_data = 64'h4321;
        tick();
        #1;
        checks++;
        if (bus.rd_rdy_a !== 1'b0 || bus.rd_data_a !== 64'h4321) begin
            errors++;
            $display("FAIL rsv_wr_same: got rdy %b data %h want 0 4321", bus.rd_rdy_a, bus.rd_data_a);
        end
        bus.wr1_en = 1; bus.wr1_addr = 7; bus.wr1_data = 64'h4321;
        tick();
    endtask

    task automatic test_reg0();
        bus.rd_addr_a = 0;
        bus.wr1_en = 1; bus.wr1_addr = 0; bus.wr1_data = 64'hFFFF;
        bus.rsv_en = 1; bus.rsv_addr = 0;
        @(negedge clk);
        checks++;
        if (bus.rd_data_a !== '0 || bus.rd_rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reg0_same_cycle: got %h rdy %b want 0 rdy 1", bus.rd_data_a, bus.rd_rdy_a);
        end
        tick();
        #1;
        checks++;
        if (bus.rd_data_a !== '0 || bus.rd_rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reg0_after: got %h rdy %b want 0 rdy 1", bus.rd_data_a, bus.rd_rdy_a);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] want;
        bus.wr0_en = 1; bus.wr0_addr = 3; bus.wr0_data = 64'h1111;
        tick();
        bus.rd_addr_b = 3;
        bus.wr0_en = 1; bus.wr0_addr = 3; bus.wr0_data = 64'hBEEF;
`ifdef REGFILE_BYPASS_EN
        want = 64'hBEEF;
`else
        want = 64'h1111;
`endif
        @(negedge clk);
        checks++;
        if (bus.rd_data_b !== want) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h want %h", bus.rd_data_b, want);
        end
        tick();
        #1;
        checks++;
        if (bus.rd_data_b !== 64'hBEEF) begin
            errors++;
            $display("FAIL bypass_next: got %h want beef", bus.rd_data_b);
        end
    endtask

    task automatic test_clear_ignores();
        bus.wr0_en = 1; bus.wr0_addr = 9;  bus.wr0_data = 64'h99;
        bus.wr1_en = 1; bus.wr1_addr = 20; bus.wr1_data = 64'hABC;
        tick();
        bus.clr_req = 1;
        tick();
        for (int c = 0; c < NREGS - 1; c++) begin
            bus.rd_addr_a = 20;
            bus.rd_addr_b = 9;
            if (c == 14) begin
                bus.wr0_en = 1; bus.wr0_addr = 9; bus.wr0_data = 64'h77;
                bus.rsv_en = 1; bus.rsv_addr = 9;
                bus.clr_req = 1;
            end
            @(negedge clk);
            checks++;
            if (bus.clr_busy !== 1'b1 || bus.rd_data_a !== exp_data(20)) begin
                errors++;
                $display("FAIL sweep_read[%0d]: got busy %b data %h want 1 %h", c, bus.clr_busy, bus.rd_data_a, exp_data(20));
            end
            tick();
        end
        #1;
        checks++;
        if (bus.clr_busy !== 1'b0 || bus.rd_data_b !== '0 || bus.rd_rdy_b !== 1'b1) begin
            errors++;
            $display("FAIL sweep_ignore: got busy %b data %h rdy %b want 0 0 1", bus.clr_busy, bus.rd_data_b, bus.rd_rdy_b);
        end
        @(negedge clk);
        checks++;
        if (bus.clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_req_in_clear: got busy %b want 0", bus.clr_busy);
        end
    endtask

    task automatic test_reset_mid();
        bus.wr0_en = 1; bus.wr0_addr = 25; bus.wr0_data = 64'h2525;
        bus.wr1_en = 1; bus.wr1_addr = 3;  bus.wr1_data = 64'h3333;
        bus.rsv_en = 1; bus.rsv_addr = 12;
        tick();
        bus.clr_req = 1;
        tick();
        for (int c = 0; c < 4; c++) tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        bus.rd_addr_a = 12;
        bus.rd_addr_b = 25;
        #1;
        checks++;
        if (bus.clr_busy !== 1'b0 || bus.rd_rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got busy %b rdy %b want 0 1", bus.clr_busy, bus.rd_rdy_a);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        #1;
        checks++;
        if (bus.clr_busy !== 1'b0 || bus.rd_data_b !== 64'h2525) begin
            errors++;
            $display("FAIL sweep_abort: got busy %b data %h want 0 2525", bus.clr_busy, bus.rd_data_b);
        end
        bus.rd_addr_a = 3;
        #1;
        checks++;
        if (bus.rd_data_a !== '0 || bus.rd_data_a !== exp_data(3)) begin
            errors++;
            $display("FAIL sweep_partial: got %h want 0", bus.rd_data_a);
        end
    endtask

    task automatic test_random();
        int pool;
        int ra, rb;
        for (int c = 0; c < 400; c++) begin
            pool = (c % 3 == 0) ? NREGS - 1 : 7;
            bus.wr0_en   = ($urandom_range(0, 2) != 0);
            bus.wr0_addr = ADDR_W'($urandom_range(0, pool));
            bus.wr0_data = {$urandom, $urandom};
            bus.wr1_en   = ($urandom_range(0, 2) == 0);
            bus.wr1_addr = ADDR_W'($urandom_range(0, pool));
            bus.wr1_data = {$urandom, $urandom};
            bus.rsv_en   = ($urandom_range(0, 1) == 1);
            bus.rsv_addr = ADDR_W'($urandom_range(0, pool));
            bus.clr_req  = (c == 200);
            ra = $urandom_range(0, pool);
            rb = $urandom_range(0, pool);
            bus.rd_addr_a = ADDR_W'(ra);
            bus.rd_addr_b = ADDR_W'(rb);
            @(negedge clk);
            checks++;
            if (bus.clr_busy !== m_busy ||
                bus.rd_rdy_a !== exp_rdy(ra) || bus.rd_rdy_b !== exp_rdy(rb) ||
                (exp_known(ra) && bus.rd_data_a !== exp_data(ra)) ||
                (exp_known(rb) && bus.rd_data_b !== exp_data(rb))) begin
                errors++;
                $display("FAIL random[%0d]: a[%0d]=%h/%b b[%0d]=%h/%b busy %b want a=%h/%b b=%h/%b busy %b",
                         c, ra, bus.rd_data_a, bus.rd_rdy_a, rb, bus.rd_data_b, bus.rd_rdy_b, bus.clr_busy,
                         exp_data(ra), exp_rdy(ra), exp_data(rb), exp_rdy(rb), m_busy);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_same_addr();
        test_pending();
        test_reg0();
        test_bypass();
        test_clear_ignores();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
